traffic_light_ctrl_n: RTL and testbench
=======================================

// Module: traffic_light_ctrl_n
// PURPOSE
//  N-approach traffic-light phase controller: successor to the fixed 4-way displayTimer.
//  Round-robin green/orange/all-red per approach, per-approach green times.
//  Latched pedestrian phase, emergency preemption, zero-green approach skipping.
//  Sits between the timebase prescaler and the lamp/display drivers.
// PARAMETERS
//  N_APP  4  number of approaches (2..8)
//  TW     8  width of every time value and of the countdown timer
//  AW     3  width of approach index; must satisfy 2**AW >= N_APP
// PORTS
//  clk       in   1        system clock, rising edge
//  reset     in   1        asynchronous, active-low reset
//  stop      in   1        1 = freeze state and timer
//  tick      in   1        timebase strobe; one phase tick per cycle with tick=1
//  em_btn    in   1        emergency request (level)
//  ped_btn   in   1        pedestrian request (pulse or level)
//  t_green   in   N_APP*TW green ticks; approach i at [i*TW +: TW]
//  t_orange  in   TW       orange ticks
//  t_allred  in   TW       all-red clearance ticks
//  t_ped     in   TW       pedestrian walk ticks
//  lights    out  N_APP*3  per approach [i*3 +: 3]: 100 red, 010 orange, 001 green
//  ped_walk  out  1        1 during PED phase
//  active    out  AW       approach currently owning / last owning green
//  timer     out  TW       remaining ticks-1 of current phase
//  state     out  3        0 ALLRED, 1 GREEN, 2 ORANGE, 3 PED, 4 EMERG
// BEHAVIOUR
//  Reset: state=ALLRED, active=0, timer=0, all lights red, ped_walk=0, ped_pending=0, resume=0.
//  Phase step: only on tick=1 && stop=0 (a "step").
//  - If timer != 0: decrement.
//  - If timer == 0: transition; the new phase loads its time T as T-1.
//  - Phase therefore lasts exactly T steps; T=0 is treated as 1.
//  Time inputs are sampled only at phase entry; mid-phase changes take effect next entry.
//  Transitions:
//  - GREEN(i) -> ORANGE(i) -> ALLRED.
//  - ALLRED -> PED if ped_pending, else GREEN(next).
//  - PED -> ALLRED; that ALLRED then proceeds to GREEN(next).
//  next = first j after active (mod N_APP, wrapping, i itself last) with t_green[j] != 0.
//  If every t_green is 0: stay ALLRED, reload t_allred, active unchanged.
//  ped_pending: set on any clk with ped_btn=1 while state != PED (tick/stop not needed);
//   cleared on entering PED. Several requests inside one cycle yield one PED phase.
//  Lights: GREEN/ORANGE drive only lights[active]; all other approaches red.
//   ALLRED, PED and EMERG drive all approaches red.
//  stop=1: state, timer, outputs frozen; ped_pending and em_btn still sampled.
//  Reset asserted mid-phase: immediate return to reset values, no orange run-out.
// CONFIGURATION
//  TLC_EMERGENCY_EN defined:
//  - em_btn=1 seen at a step in GREEN -> ORANGE(active), then EMERG;
//    in ORANGE: finish orange, then EMERG; in ALLRED or PED: EMERG at that step.
//  - Preempted PED keeps ped_pending set.
//  - EMERG loads t_allred; exits when timer==0 && em_btn==0 -> ALLRED -> GREEN(resume).
//  - resume = approach that was green or orange at preemption, else next.
//  - Resumed approach gets a full fresh green.
//  - em_btn and ped_btn at the same step: emergency wins.
//  TLC_EMERGENCY_EN undefined:
//  - em_btn ignored, EMERG unreachable, state encoding unchanged.
// STRUCTURE
//  Package tlc_pkg: state localparams (ALLRED..EMERG), lamp codes RED/ORANGE/GREEN.
//  Package tlc_pkg also holds next_app() function.
//  Sub-module tlc_next_sel: combinational rotating priority search for next non-zero-green approach.
// TESTING (N_APP=4, TW=8, tick=1 every clk, t_green={5,10,5,5} for app 0..3,
//          t_orange=3, t_allred=1, t_ped=4)
//  1 Release reset -> ALLRED 1 clk, GREEN app0 5, ORANGE 3, ALLRED 1, GREEN app1 10;
//    full cycle 41 clks, app0 green again at clk 42.
//  2 ped_btn 1-clk pulse during GREEN app1 -> after its ALLRED: PED 4 clks with ped_walk=1,
//    then ALLRED 1, GREEN app2; ped_pending cleared.
//  3 em_btn=1 at GREEN app0 clk 2, held 10 clks (EMERGENCY_EN) -> ORANGE 3, EMERG until
//    em_btn low, ALLRED 1, GREEN app0 full 5; without macro sequence matches test 1.
//  4 stop=1 for 7 clks mid GREEN app1 with timer=6 -> timer/state held at 6;
//    app1 green lasts 17 clks total.
//  5 t_green[1]=0 -> app0 ORANGE/ALLRED followed by GREEN app2;
//    all t_green=0 -> permanent ALLRED, lights all 100.
//  6 reset low during ORANGE app2 -> same clk lights all red, state=0, timer=0, active=0.

Source files
------------

// File: rtl/tlc_pkg.sv
// tlc_pkg
//   Shared definitions for the N-approach traffic-light controller.
//   - tlc_state_t : phase encoding as seen on the 'state' output
//                   (0 ALLRED, 1 GREEN, 2 ORANGE, 3 PED, 4 EMERG)
//   - LAMP_*      : per-approach lamp codes (one 3-bit field per approach)
//   - next_app()  : rotating search for the next approach with a non-zero
//                   green time
package tlc_pkg;

    typedef enum logic [2:0] {
        ST_ALLRED = 3'd0,
        ST_GREEN  = 3'd1,
        ST_ORANGE = 3'd2,
        ST_PED    = 3'd3,
        ST_EMERG  = 3'd4
    } tlc_state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_ORANGE = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // Upper bound on the number of approaches the search logic handles.
    localparam int MAX_APP = 8;

    // Returns {found, index}. Candidates are visited starting just after
    // 'cur' and wrapping, with 'cur' itself tried last. When 'incl' is set
    // (nothing has been green yet since reset) 'cur' is tried first instead.
    // Scanning from the farthest candidate towards the nearest lets the
    // nearest hit overwrite the result, so no early exit is needed.
    function automatic logic [3:0] next_app(input logic [MAX_APP-1:0] nz,
                                            input logic [2:0]         cur,
                                            input int                 n_app,
                                            input logic               incl);
        logic [3:0] res;
        logic [2:0] j;
        res = {1'b0, cur};
        for (int k = MAX_APP; k >= 0; k--) begin
            if (incl ? (k < n_app) : ((k >= 1) && (k <= n_app))) begin
                j = 3'((int'(cur) + k) % n_app);
                if (nz[j]) begin
                    res = {1'b1, j};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tlc_next_sel.sv
// tlc_next_sel
//   Combinational rotating-priority search for the next approach whose
//   green time is non-zero.
//   Ports:
//     t_green in  N_APP*TW  green times, approach i at [i*TW +: TW]
//     cur     in  AW        approach the search rotates from
//     incl    in  1         1 = 'cur' is a candidate first (start-up case)
//     nxt     out AW        selected approach (== cur when none found)
//     found   out 1         at least one approach has a non-zero green
module tlc_next_sel
    import tlc_pkg::*;
#(
    parameter int N_APP = 4,
    parameter int TW    = 8,
    parameter int AW    = 3
) (
    input  logic [N_APP*TW-1:0] t_green,
    input  logic [AW-1:0]       cur,
    input  logic                incl,
    output logic [AW-1:0]       nxt,
    output logic                found
);

    logic [MAX_APP-1:0] nz;
    logic [3:0]         res;

    // One "has green time" flag per approach; unused slots never match.
    for (genvar g = 0; g < MAX_APP; g++) begin : g_nz
        if (g < N_APP) begin : g_used
            assign nz[g] = |t_green[g*TW +: TW];
        end else begin : g_pad
            assign nz[g] = 1'b0;
        end
    end

    assign res   = next_app(nz, 3'(cur), N_APP, incl);
    assign found = res[3];
    assign nxt   = AW'(res[2:0]);

endmodule

// File: rtl/traffic_light_ctrl_n.sv
// traffic_light_ctrl_n
//   N-approach traffic-light phase controller. Approaches get green in
//   round-robin order (GREEN -> ORANGE -> ALLRED), approaches with a zero
//   green time are skipped, and a latched pedestrian request inserts a PED
//   phase after the next all-red clearance.
//   Optional feature macro: TLC_EMERGENCY_EN enables emergency preemption
//   (EMERG phase). Without it em_btn is ignored and EMERG is unreachable.
//   Ports:
//     clk      in  1         system clock, rising edge
//     reset    in  1         asynchronous, active-low reset
//     stop     in  1         1 = freeze state, timer and lamp outputs
//     tick     in  1         timebase strobe, one phase step per tick
//     em_btn   in  1         emergency request (level)
//     ped_btn  in  1         pedestrian request (pulse or level)
//     t_green  in  N_APP*TW  green ticks per approach, [i*TW +: TW]
//     t_orange in  TW        orange ticks
//     t_allred in  TW        all-red clearance ticks
//     t_ped    in  TW        pedestrian walk ticks
//     lights   out N_APP*3   lamp code per approach, [i*3 +: 3]
//     ped_walk out 1         1 while in PED
//     active   out AW        approach owning / last owning green
//     timer    out TW        remaining ticks - 1 of the current phase
//     state    out 3         current phase (tlc_state_t encoding)
module traffic_light_ctrl_n
    import tlc_pkg::*;
#(
    parameter int N_APP = 4,
    parameter int TW    = 8,
    parameter int AW    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stop,
    input  logic                tick,
    input  logic                em_btn,
    input  logic                ped_btn,
    input  logic [N_APP*TW-1:0] t_green,
    input  logic [TW-1:0]       t_orange,
    input  logic [TW-1:0]       t_allred,
    input  logic [TW-1:0]       t_ped,
    output logic [N_APP*3-1:0]  lights,
    output logic                ped_walk,
    output logic [AW-1:0]       active,
    output logic [TW-1:0]       timer,
    output logic [2:0]          state
);

    tlc_state_t         st, n_st;
    logic [AW-1:0]      n_active;
    logic [TW-1:0]      n_timer;
    logic [N_APP*3-1:0] n_lights;
    logic               n_ped_walk;
    logic               ped_pending, n_ped_pending;
    logic               fresh, n_fresh;
    logic               after_ped, n_after_ped;
    logic               step;
    logic [AW-1:0]      nxt_app;
    logic               found;
    logic               em_req;
    logic               go_emerg;
    logic [AW-1:0]      go_resume;
    logic               resume_now;
    logic [AW-1:0]      resume_app;

    // A phase of T ticks loads T-1 so it lasts exactly T steps; 0 acts as 1.
    function automatic logic [TW-1:0] load_time(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    function automatic logic [TW-1:0] green_of(input logic [N_APP*TW-1:0] tg,
                                               input logic [AW-1:0]       idx);
        logic [TW-1:0] g;
        g = '0;
        for (int i = 0; i < N_APP; i++) begin
            if (idx == AW'(i)) begin
                g = tg[i*TW +: TW];
            end
        end
        return g;
    endfunction

    assign step  = tick & ~stop;
    assign state = st;

    tlc_next_sel #(
        .N_APP (N_APP),
        .TW    (TW),
        .AW    (AW)
    ) u_next_sel (
        .t_green (t_green),
        .cur     (active),
        .incl    (fresh),
        .nxt     (nxt_app),
        .found   (found)
    );

`ifdef TLC_EMERGENCY_EN
    logic          em_pend, n_em_pend;
    logic          resume_go, n_resume_go;
    logic [AW-1:0] resume, n_resume;

    // em_pend remembers a request seen while stopped or mid-orange so the
    // preemption still happens once the phase is allowed to move.
    assign em_req     = em_btn | em_pend;
    assign resume_now = resume_go && (green_of(t_green, resume) != '0);
    assign resume_app = resume;
`else
    logic unused_em;
    assign em_req     = 1'b0;
    assign resume_now = 1'b0;
    assign resume_app = '0;
    assign unused_em  = ^{em_btn, go_emerg, go_resume};
`endif

    // Next-state logic: timers count down on each step and the phase
    // changes when the timer is already zero. Emergency entry is flagged
    // here and resolved in the emergency block below.
    always_comb begin
        n_st          = st;
        n_active      = active;
        n_timer       = timer;
        n_ped_pending = ped_pending;
        n_fresh       = fresh;
        n_after_ped   = after_ped;
        go_emerg      = 1'b0;
        go_resume     = nxt_app;

        if (ped_btn && (st != ST_PED)) begin
            n_ped_pending = 1'b1;
        end

        if (step) begin
            case (st)
                ST_GREEN: begin
                    if (em_req || (timer == '0)) begin
                        n_st    = ST_ORANGE;
                        n_timer = load_time(t_orange);
                    end else begin
                        n_timer = timer - TW'(1);
                    end
                end
                ST_ORANGE: begin
                    if (timer != '0) begin
                        n_timer = timer - TW'(1);
                    end else if (em_req) begin
                        go_emerg  = 1'b1;
                        go_resume = active;
                    end else begin
                        n_st    = ST_ALLRED;
                        n_timer = load_time(t_allred);
                    end
                end
                ST_ALLRED: begin
                    if (em_req) begin
                        go_emerg = 1'b1;
                    end else if (timer != '0) begin
                        n_timer = timer - TW'(1);
                    end else begin
                        n_after_ped = 1'b0;
                        if (resume_now) begin
                            n_st     = ST_GREEN;
                            n_active = resume_app;
                            n_timer  = load_time(green_of(t_green, resume_app));
                            n_fresh  = 1'b0;
                        end else if (ped_pending && !after_ped) begin
                            n_st          = ST_PED;
                            n_timer       = load_time(t_ped);
                            n_ped_pending = 1'b0;
                        end else if (found) begin
                            n_st     = ST_GREEN;
                            n_active = nxt_app;
                            n_timer  = load_time(green_of(t_green, nxt_app));
                            n_fresh  = 1'b0;
                        end else begin
                            n_timer = load_time(t_allred);
                        end
                    end
                end
                ST_PED: begin
                    if (em_req) begin
                        go_emerg = 1'b1;
                    end else if (timer != '0) begin
                        n_timer = timer - TW'(1);
                    end else begin
                        n_st        = ST_ALLRED;
                        n_timer     = load_time(t_allred);
                        n_after_ped = 1'b1;
                    end
                end
                ST_EMERG: begin
                    if (timer != '0) begin
                        n_timer = timer - TW'(1);
                    end else if (!em_req) begin
                        n_st    = ST_ALLRED;
                        n_timer = load_time(t_allred);
                    end
                end
                default: begin
                    n_st    = ST_ALLRED;
                    n_timer = '0;
                end
            endcase
        end

`ifdef TLC_EMERGENCY_EN
        // Emergency entry. resume is captured only once, so a second
        // preemption during the post-emergency ALLRED keeps the original
        // approach. An interrupted walk is re-queued.
        n_em_pend   = em_pend;
        n_resume    = resume;
        n_resume_go = resume_go;
        if (em_btn && (st != ST_EMERG)) begin
            n_em_pend = 1'b1;
        end
        if (step && (st == ST_ALLRED) && !em_req && (timer == '0) &&
            (n_st != ST_ALLRED)) begin
            n_resume_go = 1'b0;
        end
        if (go_emerg) begin
            n_st        = ST_EMERG;
            n_timer     = load_time(t_allred);
            n_em_pend   = 1'b0;
            n_resume_go = 1'b1;
            if (!resume_go) begin
                n_resume = go_resume;
            end
            if (st == ST_PED) begin
                n_ped_pending = 1'b1;
            end
        end
`endif

        // Lamps follow the phase being entered so they change together
        // with 'state'.
        n_lights = {N_APP{LAMP_RED}};
        for (int i = 0; i < N_APP; i++) begin
            if (n_active == AW'(i)) begin
                if (n_st == ST_GREEN) begin
                    n_lights[i*3 +: 3] = LAMP_GREEN;
                end else if (n_st == ST_ORANGE) begin
                    n_lights[i*3 +: 3] = LAMP_ORANGE;
                end
            end
        end
        n_ped_walk = (n_st == ST_PED);
    end

    // Single state register for the phase machine and its outputs. Reset
    // drops straight to all-red without running out the current orange.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= ST_ALLRED;
            active      <= '0;
            timer       <= '0;
            lights      <= {N_APP{LAMP_RED}};
            ped_walk    <= 1'b0;
            ped_pending <= 1'b0;
            fresh       <= 1'b1;
            after_ped   <= 1'b0;
`ifdef TLC_EMERGENCY_EN
            em_pend     <= 1'b0;
            resume      <= '0;
            resume_go   <= 1'b0;
`endif
        end else begin
            st          <= n_st;
            active      <= n_active;
            timer       <= n_timer;
            lights      <= n_lights;
            ped_walk    <= n_ped_walk;
            ped_pending <= n_ped_pending;
            fresh       <= n_fresh;
            after_ped   <= n_after_ped;
`ifdef TLC_EMERGENCY_EN
            em_pend     <= n_em_pend;
            resume      <= n_resume;
            resume_go   <= n_resume_go;
`endif
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// tb_traffic_light_ctrl_n
//   Self-checking bench for traffic_light_ctrl_n (N_APP=4, TW=8, tick every
//   clock). Expected phase sequences are written as tables of
//   {phase, approach, length, first timer, count/hold, inputs} records that
//   expand into one expected output record per clock on a scoreboard queue.
`timescale 1ns/1ps
module tb_traffic_light_ctrl_n;

    localparam int N_APP = 4;
    localparam int TW    = 8;
    localparam int AW    = 3;

    localparam int A = 0;
    localparam int G = 1;
    localparam int O = 2;
    localparam int P = 3;
    localparam int E = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                stop = 1'b0;
    logic                tick = 1'b1;
    logic                em_btn = 1'b0;
    logic                ped_btn = 1'b0;
    logic [N_APP*TW-1:0] t_green;
    logic [TW-1:0]       t_orange;
    logic [TW-1:0]       t_allred;
    logic [TW-1:0]       t_ped;
    logic [N_APP*3-1:0]  lights;
    logic                ped_walk;
    logic [AW-1:0]       active;
    logic [TW-1:0]       timer;
    logic [2:0]          state;

    typedef struct {
        int st;
        int app;
        int n;
        int t0;
        bit dec;
        bit ped;
        bit stp;
        bit em;
    } vec_t;

    typedef struct {
        int                 st;
        int                 app;
        int                 tmr;
        logic [N_APP*3-1:0] lamps;
        bit                 walk;
    } exp_t;

    vec_t  vecs[$];
    exp_t  sb[$];
    int    tests = 0;
    int    fails = 0;
    string tname;

    traffic_light_ctrl_n #(
        .N_APP (N_APP),
        .TW    (TW),
        .AW    (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stop     (stop),
        .tick     (tick),
        .em_btn   (em_btn),
        .ped_btn  (ped_btn),
        .t_green  (t_green),
        .t_orange (t_orange),
        .t_allred (t_allred),
        .t_ped    (t_ped),
        .lights   (lights),
        .ped_walk (ped_walk),
        .active   (active),
        .timer    (timer),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Lamp pattern the spec requires for a given phase and approach.
    function automatic logic [N_APP*3-1:0] expLamps(input int st, input int app);
        logic [N_APP*3-1:0] l;
        l = '0;
        for (int i = 0; i < N_APP; i++) begin
            l[i*3 +: 3] = 3'b100;
            if (i == app && st == G) l[i*3 +: 3] = 3'b001;
            if (i == app && st == O) l[i*3 +: 3] = 3'b010;
        end
        return l;
    endfunction

    function automatic vec_t mk(input int st, input int app, input int n, input int t0,
                                input bit dec, input bit ped, input bit stp, input bit em);
        vec_t v;
        v.st = st; v.app = app; v.n = n; v.t0 = t0;
        v.dec = dec; v.ped = ped; v.stp = stp; v.em = em;
        return v;
    endfunction

    function automatic void addv(input int st, input int app, input int n, input int t0);
        vecs.push_back(mk(st, app, n, t0, 1'b1, 1'b0, 1'b0, 1'b0));
    endfunction

    // Green of 'glen' ticks, orange 3, all-red 1 for one approach.
    function automatic void addCycle(input int app, input int glen);
        addv(G, app, glen, glen - 1);
        addv(O, app, 3, 2);
        addv(A, app, 1, 0);
    endfunction

    task automatic setGreen(input int g0, input int g1, input int g2, input int g3);
        t_green = {8'(g3), 8'(g2), 8'(g1), 8'(g0)};
    endtask

    task automatic checkOutput();
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("[TB] FAIL %s scoreboard: got an output with no expected entry", tname);
        end else begin
            e = sb.pop_front();
            if (state !== 3'(e.st) || active !== AW'(e.app) || timer !== TW'(e.tmr) ||
                lights !== e.lamps || ped_walk !== e.walk) begin
                fails++;
                $display("[TB] FAIL %s @%0t: got state=%0d active=%0d timer=%0d lights=%b walk=%0b, expected state=%0d active=%0d timer=%0d lights=%b walk=%0b",
                         tname, $time, state, active, timer, lights, ped_walk,
                         e.st, e.app, e.tmr, e.lamps, e.walk);
            end
        end
    endtask

    // Drives one clock of a record, queues its expected result and checks
    // it just after the rising edge.
    task automatic applyStimulus(input vec_t v, input int k);
        exp_t e;
        ped_btn = v.ped;
        stop    = v.stp;
        em_btn  = v.em;
        e.st    = v.st;
        e.app   = v.app;
        e.tmr   = v.dec ? v.t0 - k : v.t0;
        e.lamps = expLamps(v.st, v.app);
        e.walk  = (v.st == P);
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic runVecs();
        for (int r = 0; r < vecs.size(); r++) begin
            for (int k = 0; k < vecs[r].n; k++) begin
                applyStimulus(vecs[r], k);
            end
        end
        vecs.delete();
        ped_btn = 1'b0;
        stop    = 1'b0;
        em_btn  = 1'b0;
    endtask

    task automatic checkReset();
        exp_t e;
        e.st = A; e.app = 0; e.tmr = 0; e.lamps = expLamps(A, 0); e.walk = 1'b0;
        sb.push_back(e);
        checkOutput();
    endtask

    task automatic doReset(input string name);
        tname   = name;
        ped_btn = 1'b0;
        stop    = 1'b0;
        em_btn  = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        checkReset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        setGreen(5, 10, 5, 5);
        t_orange = 8'd3;
        t_allred = 8'd1;
        t_ped    = 8'd4;

        // Full round-robin cycle; app0 green again on clock 42.
        doReset("t1_cycle");
        addCycle(0, 5); addCycle(1, 10); addCycle(2, 5); addCycle(3, 5);
        addv(G, 0, 5, 4);
        runVecs();

        // One-clock pedestrian pulse during app1 green, served once.
        doReset("t2_ped");
        addCycle(0, 5);
        addv(G, 1, 1, 9);
        vecs.push_back(mk(G, 1, 1, 8, 1'b1, 1'b1, 1'b0, 1'b0));
        addv(G, 1, 8, 7);
        addv(O, 1, 3, 2);
        addv(A, 1, 1, 0);
        addv(P, 1, 4, 3);
        addv(A, 1, 1, 0);
        addCycle(2, 5); addCycle(3, 5);
        addv(G, 0, 5, 4);
        runVecs();

        // Emergency held for 10 clocks starting at app0 green clock 3.
        doReset("t3_emerg");
        addv(G, 0, 2, 4);
`ifdef TLC_EMERGENCY_EN
        vecs.push_back(mk(O, 0, 3, 2, 1'b1, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(E, 0, 7, 0, 1'b0, 1'b0, 1'b0, 1'b1));
        addv(A, 0, 1, 0);
        addv(G, 0, 5, 4);
        addv(O, 0, 3, 2);
        addv(A, 0, 1, 0);
        addv(G, 1, 2, 9);
`else
        vecs.push_back(mk(G, 0, 3, 2, 1'b1, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(O, 0, 3, 2, 1'b1, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(A, 0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(G, 1, 3, 9, 1'b1, 1'b0, 1'b0, 1'b1));
        addv(G, 1, 7, 6);
        addv(O, 1, 3, 2);
        addv(A, 1, 1, 0);
        addv(G, 2, 5, 4);
`endif
        runVecs();

        // Stop for 7 clocks at app1 timer 6, with a held pedestrian request
        // that must still latch and produce exactly one walk phase.
        doReset("t4_stop");
        addCycle(0, 5);
        addv(G, 1, 4, 9);
        vecs.push_back(mk(G, 1, 7, 6, 1'b0, 1'b1, 1'b1, 1'b0));
        addv(G, 1, 6, 5);
        addv(O, 1, 3, 2);
        addv(A, 1, 1, 0);
        addv(P, 1, 4, 3);
        addv(A, 1, 1, 0);
        addCycle(2, 5);
        addv(G, 3, 2, 4);
        runVecs();

        // Zero green on app1 is skipped, including on wrap-around.
        setGreen(5, 0, 5, 5);
        doReset("t5_skip");
        addCycle(0, 5); addCycle(2, 5); addCycle(3, 5);
        addv(G, 0, 5, 4);
        runVecs();

        // All greens zero: permanent all-red with t_allred reloaded.
        setGreen(0, 0, 0, 0);
        t_allred = 8'd3;
        doReset("t5_allzero");
        addv(A, 0, 3, 2); addv(A, 0, 3, 2); addv(A, 0, 3, 2);
        runVecs();
        t_allred = 8'd1;
        setGreen(5, 10, 5, 5);

        // Asynchronous reset in the middle of app2 orange.
        doReset("t6_async");
        addCycle(0, 5); addCycle(1, 10);
        addv(G, 2, 5, 4);
        addv(O, 2, 1, 2);
        runVecs();
        tname = "t6_async_reset";
        #3;
        reset = 1'b0;
        #1;
        checkReset();
        @(posedge clk);
        #1;
        checkReset();
        @(negedge clk);
        reset = 1'b1;
        tname = "t6_restart";
        addv(G, 0, 2, 4);
        runVecs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
